// File: rtl/rr_arb_4b_5to1.sv
// Round-robin arbiter sharing one registered NBITS-wide output among five val/rdy requesters.
// Optional lock input (burst priority hold) is built when RR_ARB_LOCK_EN is defined.
module rr_arb_4b_5to1 #(
    parameter int unsigned NBITS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    input  logic [NBITS-1:0] in2,
    input  logic [NBITS-1:0] in3,
    input  logic [NBITS-1:0] in4,
    input  logic [4:0]       in_val,
    output logic [4:0]       in_rdy,
    output logic [NBITS-1:0] out,
    output logic             out_val,
    input  logic             out_rdy,
    output logic [2:0]       out_sel
`ifdef RR_ARB_LOCK_EN
    ,
    input  logic             lock
`endif
);

    localparam int unsigned NREQ = 5;

    logic [2:0]       ptr;
    logic [2:0]       ptr_nxt;
    logic [2:0]       ptr_adv;
    logic [2:0]       win;
    logic [3:0]       scan;
    logic             found;
    logic             can_accept;
    logic             fire;
    logic [NBITS-1:0] msg;

    // Priority scan starting at ptr with wrap 4->0; never looks at message data.
    always_comb begin
        found      = 1'b0;
        win        = 3'd0;
        scan       = 4'd0;
        can_accept = !out_val || out_rdy;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan = 4'(ptr) + 4'(k);
            if (scan >= 4'(NREQ)) begin
                scan = scan - 4'(NREQ);
            end
            if (!found && in_val[scan[2:0]]) begin
                found = 1'b1;
                win   = scan[2:0];
            end
        end
        fire   = found && can_accept && !reset;
        in_rdy = fire ? (5'b00001 << win) : 5'b00000;
    end

    always_comb begin
        msg = '0;
        case (win)
            3'd0:    msg = in0;
            3'd1:    msg = in1;
            3'd2:    msg = in2;
            3'd3:    msg = in3;
            3'd4:    msg = in4;
            default: msg = '0;
        endcase
    end

    // Pointer advance; a locked fire keeps the current winner at top priority.
    always_comb begin
        ptr_adv = (win == 3'd4) ? 3'd0 : win + 3'd1;
`ifdef RR_ARB_LOCK_EN
        ptr_nxt = lock ? win : ptr_adv;
`else
        ptr_nxt = ptr_adv;
`endif
    end

    // Output register: a same-cycle drain and accept replaces the message with no bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out     <= '0;
            out_val <= 1'b0;
            out_sel <= 3'd0;
            ptr     <= 3'd0;
        end else if (fire) begin
            out     <= msg;
            out_val <= 1'b1;
            out_sel <= win;
            ptr     <= ptr_nxt;
        end else if (out_val && out_rdy) begin
            out_val <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_4b_5to1.sv
// Directed bench for rr_arb_4b_5to1: in_rdy checked at issue, out/out_sel checked by a scoreboard monitor.
module tb_rr_arb_4b_5to1;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_msg [5];
    logic [4:0] in_val;
    logic [4:0] in_rdy;
    logic [3:0] out;
    logic       out_val;
    logic       out_rdy;
    logic [2:0] out_sel;
    logic       lock;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [3:0] msg;
        logic [2:0] sel;
    } exp_t;

    exp_t sb [$];

    always #5 clk = ~clk;

    rr_arb_4b_5to1 dut (
        .clk     (clk),
        .reset   (reset),
        .in0     (in_msg[0]),
        .in1     (in_msg[1]),
        .in2     (in_msg[2]),
        .in3     (in_msg[3]),
        .in4     (in_msg[4]),
        .in_val  (in_val),
        .in_rdy  (in_rdy),
        .out     (out),
        .out_val (out_val),
        .out_rdy (out_rdy),
        .out_sel (out_sel)
`ifdef RR_ARB_LOCK_EN
        ,
        .lock    (lock)
`endif
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, got, exp);
        end
    endtask

    // Monitor: every cycle with out_val && out_rdy consumes one expected message.
    always @(negedge clk) begin
        if (!reset && out_val && out_rdy) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got out=%0d sel=%0d want=none", out, out_sel);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_msg", 32'(out), 32'(e.msg));
                chk("out_sel", 32'(out_sel), 32'(e.sel));
            end
        end
    end

    // One cycle of stimulus: drive, check in_rdy, queue any expected output, advance.
    task automatic cyc(input logic [4:0] v, input logic ordy, input logic lk,
                       input logic [4:0] exp_rdy, input string name);
        exp_t e;
        in_val  = v;
        out_rdy = ordy;
        lock    = lk;
        #2;
        chk(name, 32'(in_rdy), 32'(exp_rdy));
        for (int i = 0; i < 5; i++) begin
            if (exp_rdy[i]) begin
                e.msg = in_msg[i];
                e.sel = 3'(i);
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        in_val  = 5'b00000;
        out_rdy = 1'b0;
        lock    = 1'b0;
        for (int i = 0; i < 5; i++) in_msg[i] = 4'(i + 1);
        @(posedge clk); #1;
        in_val = 5'b11111;
        #1;
        chk("rst_out_val", 32'(out_val), 0);
        chk("rst_out", 32'(out), 0);
        chk("rst_out_sel", 32'(out_sel), 0);
        chk("rst_in_rdy", 32'(in_rdy), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Rotation with all requesters valid
        cyc(5'b11111, 1'b1, 1'b0, 5'b00001, "rot0");
        cyc(5'b11111, 1'b1, 1'b0, 5'b00010, "rot1");
        cyc(5'b11111, 1'b1, 1'b0, 5'b00100, "rot2");
        cyc(5'b11111, 1'b1, 1'b0, 5'b01000, "rot3");
        cyc(5'b11111, 1'b1, 1'b0, 5'b10000, "rot4");
        cyc(5'b11111, 1'b1, 1'b0, 5'b00001, "rot5");

        // Wrap priority after a grant to 4
        cyc(5'b10000, 1'b1, 1'b0, 5'b10000, "to4");
        cyc(5'b10001, 1'b1, 1'b0, 5'b00001, "wrap0");
        cyc(5'b10001, 1'b1, 1'b0, 5'b10000, "wrap4");

        // Backpressure
        in_msg[2] = 4'd9;
        cyc(5'b00100, 1'b1, 1'b0, 5'b00100, "bp_acc");
        for (int n = 0; n < 3; n++) begin
            cyc(5'b11111, 1'b0, 1'b0, 5'b00000, "bp_stall");
            chk("bp_out", 32'(out), 9);
            chk("bp_sel", 32'(out_sel), 2);
            chk("bp_val", 32'(out_val), 1);
        end
        cyc(5'b11111, 1'b1, 1'b0, 5'b01000, "bp_release");

        // Drain with no new request; pointer must hold at 4
        cyc(5'b00000, 1'b1, 1'b0, 5'b00000, "drain");
        chk("drain_val", 32'(out_val), 0);
        chk("drain_out", 32'(out), 4);
        chk("drain_sel", 32'(out_sel), 3);
        cyc(5'b11111, 1'b1, 1'b0, 5'b10000, "ptr_held");

        // Reset with a message pending
        cyc(5'b00001, 1'b1, 1'b0, 5'b00001, "pre_rst");
        cyc(5'b00000, 1'b0, 1'b0, 5'b00000, "pending");
        chk("pending_val", 32'(out_val), 1);
        reset  = 1'b1;
        in_val = 5'b11111;
        #2;
        chk("mid_rst_val", 32'(out_val), 0);
        chk("mid_rst_out", 32'(out), 0);
        chk("mid_rst_sel", 32'(out_sel), 0);
        chk("mid_rst_rdy", 32'(in_rdy), 0);
        sb.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        cyc(5'b11111, 1'b1, 1'b0, 5'b00001, "post_rst");

`ifdef RR_ARB_LOCK_EN
        // Locked burst to requester 1, then release
        cyc(5'b01010, 1'b1, 1'b1, 5'b00010, "lock0");
        cyc(5'b01010, 1'b1, 1'b1, 5'b00010, "lock1");
        cyc(5'b01010, 1'b1, 1'b1, 5'b00010, "lock2");
        cyc(5'b01010, 1'b1, 1'b0, 5'b00010, "unlock");
        cyc(5'b01010, 1'b1, 1'b0, 5'b01000, "after_unlock");
`endif

        cyc(5'b00000, 1'b1, 1'b0, 5'b00000, "final_drain");
        @(posedge clk); #1;
        chk("sb_empty", 32'(sb.size()), 0);
        chk("final_val", 32'(out_val), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
